// File: rtl/ddr_cmd_pkg.sv
// ddr_cmd_pkg: shared definitions for the DDR3 command front end.
// Holds the 34-bit command field layout and the read/write encoding
// used by cmd_issue_frontend and its FIFO.
package ddr_cmd_pkg;

  localparam int unsigned CMD_W        = 34;

  localparam int unsigned CMD_RANK_MSB = 33;
  localparam int unsigned CMD_RANK_LSB = 32;
  localparam int unsigned CMD_RW       = 31;
  localparam int unsigned CMD_ROW_MSB  = 29;
  localparam int unsigned CMD_ROW_LSB  = 17;
  localparam int unsigned CMD_BL       = 15;
  localparam int unsigned CMD_AP       = 13;
  localparam int unsigned CMD_COL_MSB  = 12;
  localparam int unsigned CMD_COL_LSB  = 3;
  localparam int unsigned CMD_BANK_MSB = 2;
  localparam int unsigned CMD_BANK_LSB = 0;

  typedef enum logic {
    RW_WRITE = 1'b0,
    RW_READ  = 1'b1
  } rw_e;

endpackage

// File: rtl/cmd_sync_fifo.sv
// cmd_sync_fifo: single-clock show-ahead FIFO.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en, wr_data       push request/data (ignored when full)
//   rd_en                pop request (ignored when empty)
//   rd_data              current head entry (valid when !empty)
//   count, full, empty   registered occupancy status
import ddr_cmd_pkg::*;

module cmd_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cmd_issue_frontend.sv
// cmd_issue_frontend: in-order command buffer between traffic source and
// the DDR3 controller.
// Optional feature macro: RD_TAG_FIFO_EN (tag each returning read with the
// command that requested it on host_rdata_addr; tied to 0 when undefined).
// Ports:
//   clk, power_on_rst_n                     clock, async active-low reset
//   host_cmd_valid/ready, host_command,     host command handshake; write
//   host_write_data                         data travels with the command
//   command, valid, write_data              registered issue to controller
//   ba_cmd_pm                               per-bank issue permission
//   read_data, read_data_valid              read return from controller
//   host_rdata, host_rdata_valid,           registered read return to host
//   host_rdata_addr
//   rd_outstanding                          reads issued, not yet returned
//   err_rd_unexp                            sticky unexpected-return flag
import ddr_cmd_pkg::*;

module cmd_issue_frontend #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned CMD_DEPTH  = 8,
  parameter int unsigned MAX_RD_OUT = 16
) (
  input  logic                          clk,
  input  logic                          power_on_rst_n,
  input  logic                          host_cmd_valid,
  output logic                          host_cmd_ready,
  input  logic [33:0]                   host_command,
  input  logic [DATA_W-1:0]             host_write_data,
  output logic [33:0]                   command,
  output logic                          valid,
  output logic [DATA_W-1:0]             write_data,
  input  logic [7:0]                    ba_cmd_pm,
  input  logic [DATA_W-1:0]             read_data,
  input  logic                          read_data_valid,
  output logic [DATA_W-1:0]             host_rdata,
  output logic                          host_rdata_valid,
  output logic [33:0]                   host_rdata_addr,
  output logic [$clog2(MAX_RD_OUT):0]   rd_outstanding,
  output logic                          err_rd_unexp
);

  localparam int unsigned RO_W = $clog2(MAX_RD_OUT) + 1;
  localparam int unsigned QW   = CMD_W + DATA_W;

  logic [QW-1:0]                  head;
  logic [CMD_W-1:0]               head_cmd;
  logic [DATA_W-1:0]              head_data;
  logic [$clog2(CMD_DEPTH):0]     cmd_count;
  logic                           cmd_full;
  logic                           cmd_empty;
  logic                           push;
  logic                           head_is_read;
  logic                           rd_at_max;
  logic                           issue;
  logic                           rd_issue;
  logic                           rd_return;
  logic                           rd_unexp;

  assign {head_cmd, head_data} = head;

  // Ready depends only on the registered FIFO count, never on ba_cmd_pm.
  assign host_cmd_ready = !cmd_full;
  assign push           = host_cmd_valid && host_cmd_ready;

  assign head_is_read = (head_cmd[CMD_RW] == RW_READ);
  assign rd_at_max    = (rd_outstanding == RO_W'(MAX_RD_OUT));
  assign issue        = !cmd_empty
                     && ba_cmd_pm[head_cmd[CMD_BANK_MSB:CMD_BANK_LSB]]
                     && !(head_is_read && rd_at_max);
  assign rd_issue     = issue && head_is_read;
  assign rd_return    = read_data_valid && (rd_outstanding != '0);

  cmd_sync_fifo #(
    .WIDTH (QW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (power_on_rst_n),
    .wr_en   (push),
    .wr_data ({host_command, host_write_data}),
    .rd_en   (issue),
    .rd_data (head),
    .count   (cmd_count),
    .full    (cmd_full),
    .empty   (cmd_empty)
  );

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      valid      <= 1'b0;
      command    <= '0;
      write_data <= '0;
    end else if (issue) begin
      valid      <= 1'b1;
      command    <= head_cmd;
      write_data <= head_is_read ? '0 : head_data;
    end else begin
      valid      <= 1'b0;
      command    <= '0;
      write_data <= '0;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      rd_outstanding <= '0;
    end else begin
      unique case ({rd_issue, rd_return})
        2'b10:   rd_outstanding <= rd_outstanding + RO_W'(1);
        2'b01:   rd_outstanding <= rd_outstanding - RO_W'(1);
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      host_rdata       <= '0;
      host_rdata_valid <= 1'b0;
    end else begin
      host_rdata_valid <= read_data_valid;
      if (read_data_valid) host_rdata <= read_data;
    end
  end

`ifdef RD_TAG_FIFO_EN
  logic [CMD_W-1:0]               tag_head;
  logic [$clog2(MAX_RD_OUT):0]    tag_count;
  logic                           tag_full;
  logic                           tag_empty;

  // Reads are throttled at MAX_RD_OUT, so the tag FIFO can never overflow.
  cmd_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (MAX_RD_OUT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (power_on_rst_n),
    .wr_en   (rd_issue),
    .wr_data (head_cmd),
    .rd_en   (read_data_valid),
    .rd_data (tag_head),
    .count   (tag_count),
    .full    (tag_full),
    .empty   (tag_empty)
  );

  assign rd_unexp = read_data_valid && ((rd_outstanding == '0) || tag_empty);

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      host_rdata_addr <= '0;
    end else if (read_data_valid) begin
      host_rdata_addr <= tag_empty ? '0 : tag_head;
    end
  end

  logic unused_status;
  assign unused_status = ^{cmd_count, tag_count, tag_full};
`else
  assign rd_unexp        = read_data_valid && (rd_outstanding == '0);
  assign host_rdata_addr = '0;

  logic unused_status;
  assign unused_status = ^cmd_count;
`endif

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      err_rd_unexp <= 1'b0;
    end else if (rd_unexp) begin
      err_rd_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_issue_frontend.sv
// tb_cmd_issue_frontend: scoreboard bench for cmd_issue_frontend.
// Stimulus pushes the expected issue order into a queue; a negedge monitor
// pops and compares whenever the DUT issues, and tracks read bookkeeping
// with a simple arithmetic model.
module tb_cmd_issue_frontend;

  localparam int unsigned DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              host_cmd_valid;
  logic              host_cmd_ready;
  logic [33:0]       host_command;
  logic [DATA_W-1:0] host_write_data;
  logic [33:0]       command;
  logic              valid;
  logic [DATA_W-1:0] write_data;
  logic [7:0]        ba_cmd_pm;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rdata_valid;
  logic [33:0]       host_rdata_addr;
  logic [4:0]        rd_outstanding;
  logic              err_rd_unexp;

  always #5 clk = ~clk;

  cmd_issue_frontend #(
    .DATA_W     (DATA_W),
    .CMD_DEPTH  (8),
    .MAX_RD_OUT (16)
  ) dut (
    .clk              (clk),
    .power_on_rst_n   (rst_n),
    .host_cmd_valid   (host_cmd_valid),
    .host_cmd_ready   (host_cmd_ready),
    .host_command     (host_command),
    .host_write_data  (host_write_data),
    .command          (command),
    .valid            (valid),
    .write_data       (write_data),
    .ba_cmd_pm        (ba_cmd_pm),
    .read_data        (read_data),
    .read_data_valid  (read_data_valid),
    .host_rdata       (host_rdata),
    .host_rdata_valid (host_rdata_valid),
    .host_rdata_addr  (host_rdata_addr),
    .rd_outstanding   (rd_outstanding),
    .err_rd_unexp     (err_rd_unexp)
  );

  typedef struct {
    logic [33:0]       c;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [33:0] tag_q[$];
  int          issue_cyc[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_issued = 0;
  int          cyc = 0;
  int          mdl_out = 0;
  logic        mdl_err = 1'b0;
  logic [DATA_W-1:0] hr_model = '0;
  logic [33:0] hra_model = '0;

  logic [7:0]        pm_last = '0;
  logic              rdv_last = 1'b0;
  logic [DATA_W-1:0] rd_last = '0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mk_cmd(input logic rw, input logic [12:0] row,
                                         input logic [9:0] col, input logic [2:0] bank);
    return {2'($urandom), rw, 1'b0, row, 1'b0, 1'($urandom), 1'b0, 1'($urandom), col, bank};
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    pm_last  = ba_cmd_pm;
    rdv_last = read_data_valid;
    rd_last  = read_data;
    cyc++;
  end

  // Monitor: issue order, bank permission, read throttle, read return.
  always @(negedge clk) begin
    int   old;
    exp_t e;
    logic ri;
    if (rst_n) begin
      old = mdl_out;
      if (rdv_last) begin
        hr_model = rd_last;
`ifdef RD_TAG_FIFO_EN
        hra_model = (tag_q.size() > 0) ? tag_q.pop_front() : 34'd0;
`endif
      end
      ri = 1'b0;
      if (valid) begin
        n_issued++;
        issue_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("issue_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("issue_cmd", command, e.c);
          chk("issue_wdata", write_data, e.d);
          chk("issue_bank_perm", pm_last[command[2:0]], 1);
          if (e.c[31]) begin
            ri = 1'b1;
            chk("issue_rd_limit", (old < 16), 1);
            tag_q.push_back(e.c);
          end
        end
      end else begin
        chk("idle_cmd", command, 0);
        chk("idle_wdata", write_data, 0);
      end
      mdl_out = old + (ri ? 1 : 0) - ((rdv_last && old > 0) ? 1 : 0);
      if (rdv_last && old == 0) mdl_err = 1'b1;
      chk("rd_outstanding", rd_outstanding, mdl_out);
      chk("err_rd_unexp", err_rd_unexp, mdl_err);
      chk("host_rdata_valid", host_rdata_valid, rdv_last);
      chk("host_rdata", host_rdata, hr_model);
      chk("host_rdata_addr", host_rdata_addr, hra_model);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    host_cmd_valid = 1'b0;
    read_data_valid = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_command", command, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_rd_out", rd_outstanding, 0);
    chk("rst_ready", host_cmd_ready, 1);
    chk("rst_err", err_rd_unexp, 0);
    chk("rst_hrv", host_rdata_valid, 0);
    chk("rst_hrdata", host_rdata, 0);
    chk("rst_hraddr", host_rdata_addr, 0);
    exp_q.delete();
    tag_q.delete();
    mdl_out = 0;
    mdl_err = 1'b0;
    hr_model = '0;
    hra_model = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offers one command and waits (bounded) for the handshake edge.
  task automatic push_cmd(input logic [33:0] c, input logic [DATA_W-1:0] d);
    int t = 0;
    host_command = c;
    host_write_data = d;
    host_cmd_valid = 1'b1;
    @(negedge clk);
    while (!host_cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!host_cmd_ready) begin
      chk("push_timeout", 0, 1);
      host_cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back('{c: c, d: (c[31] ? '0 : d)});
      #1 host_cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      step(1);
      t++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [33:0]       c;
    logic [DATA_W-1:0] d;
    int                n0;
    int                sent;
    int                t;
    logic              rdy;
    logic              hs;

    host_cmd_valid = 1'b0;
    host_command = '0;
    host_write_data = '0;
    ba_cmd_pm = '0;
    read_data = '0;
    read_data_valid = 1'b0;
    do_reset();
    step(1);

    // Single write: 2-cycle issue latency on an empty FIFO.
    ba_cmd_pm = 8'h01;
    c = mk_cmd(1'b0, 13'd3, 10'd5, 3'd0);
    d = {16{8'hA5}};
    push_cmd(c, d);
    @(negedge clk);
    chk("lat_early", valid, 0);
    @(negedge clk);
    chk("lat_valid", valid, 1);
    chk("lat_cmd", command, c);
    chk("lat_wdata", write_data, d);
    step(2);

    // Head-of-line blocking: bank 1 head blocks the bank 0 entry behind it.
    n0 = n_issued;
    push_cmd(mk_cmd(1'b0, 13'd10, 10'd1, 3'd1), rnd_data());
    push_cmd(mk_cmd(1'b0, 13'd11, 10'd2, 3'd0), rnd_data());
    step(5);
    chk("gate_blocked", n_issued, n0);
    ba_cmd_pm = 8'h03;
    step(4);
    chk("gate_both", n_issued, n0 + 2);
    chk("gate_consecutive", issue_cyc[issue_cyc.size()-1] - issue_cyc[issue_cyc.size()-2], 1);

    // Fill to capacity, then release all banks.
    ba_cmd_pm = 8'h00;
    for (int i = 0; i < 8; i++)
      push_cmd(mk_cmd(1'b0, 13'($urandom), 10'($urandom), 3'($urandom)), rnd_data());
    @(negedge clk);
    chk("full_ready", host_cmd_ready, 0);
    step(1);
    ba_cmd_pm = 8'hFF;
    wait_drain("full_drain");

    // Randomized mixed traffic: random permission, random read returns.
    sent = 0;
    t = 0;
    while ((sent < 40 || exp_q.size() > 0 || rd_outstanding != 0) && t < 3000) begin
      if (!host_cmd_valid && sent < 40 && ($urandom % 2 == 0)) begin
        host_command = mk_cmd(1'($urandom), 13'($urandom), 10'($urandom), 3'($urandom));
        host_write_data = rnd_data();
        host_cmd_valid = 1'b1;
      end
      ba_cmd_pm = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
      read_data_valid = (rd_outstanding != 0) && ($urandom % 2 == 0);
      read_data = rnd_data();
      @(negedge clk);
      rdy = host_cmd_ready;
      @(posedge clk);
      hs = host_cmd_valid && rdy;
      if (hs) begin
        exp_q.push_back('{c: host_command,
                          d: (host_command[31] ? '0 : host_write_data)});
        sent++;
      end
      #1;
      if (hs) host_cmd_valid = 1'b0;
      t++;
    end
    read_data_valid = 1'b0;
    chk("rand_sent", sent, 40);
    chk("rand_drain", exp_q.size(), 0);
    step(2);

    // Read throttle at 16 outstanding.
    ba_cmd_pm = 8'hFF;
    for (int i = 0; i < 20; i++)
      push_cmd(mk_cmd(1'b1, 13'(i), 10'(i * 3), 3'($urandom)), rnd_data());
    step(10);
    chk("thr_out16", rd_outstanding, 16);
    chk("thr_queued", exp_q.size(), 4);
    read_data_valid = 1'b1;
    read_data = rnd_data();
    step(1);
    read_data_valid = 1'b0;
    step(5);
    chk("thr_one_more", exp_q.size(), 3);
    chk("thr_still16", rd_outstanding, 16);
    t = 0;
    while ((exp_q.size() > 0 || rd_outstanding != 0) && t < 300) begin
      read_data_valid = (rd_outstanding != 0) && ($urandom % 4 != 0);
      read_data = rnd_data();
      step(1);
      t++;
    end
    read_data_valid = 1'b0;
    step(2);
    chk("thr_drained", rd_outstanding, 0);

    // Unexpected return: forwarded, flag set and sticky.
    read_data_valid = 1'b1;
    read_data = rnd_data();
    step(1);
    read_data_valid = 1'b0;
    @(negedge clk);
    chk("unexp_hrv", host_rdata_valid, 1);
    chk("unexp_err", err_rd_unexp, 1);
    step(5);
    chk("unexp_sticky", err_rd_unexp, 1);

    // Reset mid-stream with 3 reads outstanding and 5 commands queued.
    ba_cmd_pm = 8'hFF;
    for (int i = 0; i < 3; i++)
      push_cmd(mk_cmd(1'b1, 13'(100 + i), 10'(i), 3'(i)), rnd_data());
    step(4);
    ba_cmd_pm = 8'h00;
    for (int i = 0; i < 5; i++)
      push_cmd(mk_cmd(1'b0, 13'($urandom), 10'($urandom), 3'($urandom)), rnd_data());
    step(1);
    chk("pre_rst_out", rd_outstanding, 3);
    chk("pre_rst_queued", exp_q.size(), 5);
    @(negedge clk);
    #2;
    do_reset();
    step(3);
    chk("post_rst_idle", n_issued, n_issued);

    // Reads after reset: returns carry matching tags when tagging is built in.
    ba_cmd_pm = 8'hFF;
    for (int i = 0; i < 4; i++)
      push_cmd(mk_cmd(1'b1, 13'(200 + i), 10'(40 + i), 3'(i + 2)), rnd_data());
    step(6);
    for (int i = 0; i < 4; i++) begin
      read_data_valid = 1'b1;
      read_data = rnd_data();
      step(1);
    end
    read_data_valid = 1'b0;
    step(3);
    chk("post_rst_out", rd_outstanding, 0);
    chk("post_rst_err", err_rd_unexp, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
